// File: rtl/chest_pkg.sv
// rtl/chest_pkg.sv - shared types and constants for the chest dispatcher
package chest_pkg;

    localparam int ALGO_W = 6;
    localparam int NUM_ALGOS_DEFAULT = 50;
    localparam logic [ALGO_W-1:0] ALGO_IDLE_SEL = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_BAD_ID  = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_t;

endpackage

// File: rtl/chest_req_fifo.sv
// rtl/chest_req_fifo.sv - request queue, power-of-two depth, full/empty flags
module chest_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chest_dispatcher.sv
// rtl/chest_dispatcher.sv - queues algorithm requests and drives the framework select
// Optional WAIT timeout enabled by defining CHEST_DISPATCH_TIMEOUT_EN.
module chest_dispatcher
    import chest_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NUM_ALGOS      = NUM_ALGOS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ALGO_W-1:0] req_algo,
    output logic              req_ready,
    output logic [ALGO_W-1:0] algo_select,
    input  logic              algorithm_ready,
    output logic              rsp_valid,
    output logic [ALGO_W-1:0] rsp_algo,
    output logic [1:0]        rsp_status,
    input  logic              rsp_ready,
    output logic              busy
);
    state_t            state;
    state_t            state_nxt;
    logic              ready_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ALGO_W-1:0] fifo_dout;
    logic              fifo_pop;
    logic              id_ok;
    logic              to_expire;

    // ready_en keeps req_ready low through reset and for the cycle it is released.
    assign req_ready = ready_en && !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign id_ok     = (int'(fifo_dout) < NUM_ALGOS);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    chest_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ALGO_W)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && req_ready),
        .din   (req_algo),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CHEST_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    assign to_expire = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ST_SELECT) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT && !to_expire) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!fifo_empty) state_nxt = id_ok ? ST_SELECT : ST_RESP;
            ST_SELECT: state_nxt = ST_WAIT;
            ST_WAIT:   if (algorithm_ready || to_expire) state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Ready takes priority over an expiring timeout in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            algo_select <= ALGO_IDLE_SEL;
            rsp_algo    <= '0;
            rsp_status  <= RSP_OK;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        rsp_algo <= fifo_dout;
                        if (id_ok) begin
                            algo_select <= fifo_dout;
                        end else begin
                            rsp_status <= RSP_BAD_ID;
                        end
                    end
                end
                ST_WAIT: begin
                    if (algorithm_ready) begin
                        algo_select <= ALGO_IDLE_SEL;
                        rsp_status  <= RSP_OK;
                    end else if (to_expire) begin
                        algo_select <= ALGO_IDLE_SEL;
                        rsp_status  <= RSP_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chest_dispatcher.sv
// tb/tb_chest_dispatcher.sv - scoreboard bench for chest_dispatcher
module tb_chest_dispatcher;
    localparam int NUM_ALGOS = 50;
    localparam int TIMEOUT   = 16;
    localparam int DEPTH     = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_algo = '0;
    logic       req_ready;
    logic [5:0] algo_select;
    logic       algorithm_ready;
    logic       rsp_valid;
    logic [5:0] rsp_algo;
    logic [1:0] rsp_status;
    logic       rsp_ready = 1'b0;
    logic       busy;

    chest_dispatcher #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT),
        .NUM_ALGOS      (NUM_ALGOS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_algo        (req_algo),
        .req_ready       (req_ready),
        .algo_select     (algo_select),
        .algorithm_ready (algorithm_ready),
        .rsp_valid       (rsp_valid),
        .rsp_algo        (rsp_algo),
        .rsp_status      (rsp_status),
        .rsp_ready       (rsp_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int accepted = 0;
    bit fw_never = 1'b0;
    int fw_max_delay = 0;
    bit rsp_rand = 1'b0;
    bit rsp_force = 1'b1;

    typedef struct {
        logic [5:0] id;
        logic [1:0] st;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Framework stand-in: registered ready some cycles after a valid select appears.
    int fw_age = 0;
    int fw_delay = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            algorithm_ready <= 1'b0;
            fw_age          <= 0;
            fw_delay        <= 0;
        end else begin
            if (algo_select == 6'h3F) begin
                fw_age   <= 0;
                fw_delay <= $urandom_range(0, fw_max_delay);
            end else begin
                fw_age <= fw_age + 1;
            end
            algorithm_ready <= !fw_never && (int'(algo_select) < NUM_ALGOS) && (fw_age >= fw_delay);
        end
    end

    always begin
        @(posedge clk);
        #1;
        rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_force;
    end

    // Expected outcome of one request; 3 means no response is ever produced.
    function automatic logic [1:0] model_status(input logic [5:0] id);
        if (int'(id) >= NUM_ALGOS) return 2'd1;
        if (fw_never) begin
`ifdef CHEST_DISPATCH_TIMEOUT_EN
            return 2'd2;
`else
            return 2'd3;
`endif
        end
        return 2'd0;
    endfunction

    logic [1:0] mon_st;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                accepted++;
                mon_st = model_status(req_algo);
                if (mon_st != 2'd3) exp_q.push_back('{id: req_algo, st: mon_st});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", int'(rsp_algo), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_algo", int'(rsp_algo), int'(mon_e.id));
                    check("rsp_status", int'(rsp_status), int'(mon_e.st));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] id, output int acc);
        acc = -1;
        req_valid = 1'b1;
        req_algo  = id;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("push_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input string name, output int at);
        int n = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) check({name, "_rsp_timeout"}, 0, 1);
        else at = cyc;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_q"}, exp_q.size(), 0);
        check({name, "_drain_busy"}, int'(busy), 0);
        step(1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_req_ready"}, int'(req_ready), 0);
        check({name, "_algo_select"}, int'(algo_select), 63);
        check({name, "_rsp_valid"}, int'(rsp_valid), 0);
        check({name, "_rsp_algo"}, int'(rsp_algo), 0);
        check({name, "_rsp_status"}, int'(rsp_status), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic release_reset(input string name);
        rst_n = 1'b1;
        @(negedge clk);
        check({name, "_ready_before_edge"}, int'(req_ready), 0);
        @(negedge clk);
        check({name, "_ready_after_edge"}, int'(req_ready), 1);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", checks);
        $fatal(1);
    end

    initial begin
        int k, at, rel, a0, a1, a2, a3, a4;
        bit bad;

        step(2);
        check_reset_vals("reset");
        release_reset("reset");

        // Prompt framework: id 7
        push(6'd7, k);
        @(negedge clk);
        check("sel_before_pop", int'(algo_select), 63);
        @(negedge clk);
        check("sel_after_pop", int'(algo_select), 7);
        wait_rsp("id7", at);
        check("id7_latency", at - k, 3);
        check("id7_rsp_algo", int'(rsp_algo), 7);
        @(negedge clk);
        check("id7_rsp_done", int'(rsp_valid), 0);
        check("id7_sel_idle", int'(algo_select), 63);
        check("id7_busy_low", int'(busy), 0);
        step(1);

        // Invalid id
        push(6'd55, k);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (algo_select != 6'h3F) bad = 1'b1;
        end
        check("id55_sel_idle", int'(bad), 0);
        drain("id55");

        // Framework never answers
        fw_never = 1'b1;
        push(6'd12, k);
`ifdef CHEST_DISPATCH_TIMEOUT_EN
        wait_rsp("timeout", at);
        check("timeout_latency", at - k, TIMEOUT + 2);
        drain("timeout");
`else
        repeat (60) @(negedge clk);
        check("nowait_busy", int'(busy), 1);
        check("nowait_rsp_valid", int'(rsp_valid), 0);
        check("nowait_sel", int'(algo_select), 12);
        step(1);
        rst_n = 1'b0;
        exp_q.delete();
        step(2);
        release_reset("nowait");
`endif
        fw_never = 1'b0;

        // Queue fill while a response is held
        rsp_force = 1'b0;
        step(1);
        push(6'd20, k);
        wait_rsp("blocker", at);
        step(1);
        push(6'd1, a0);
        push(6'd2, a1);
        push(6'd3, a2);
        push(6'd4, a3);
        check("fill_back_to_back", a3 - a0, 3);
        @(negedge clk);
        check("fill_full_ready", int'(req_ready), 0);
        rel = 0;
        fork
            push(6'd5, a4);
            begin
                step(3);
                @(negedge clk);
                check("fill_held_ready", int'(req_ready), 0);
                rel = cyc;
                rsp_force = 1'b1;
            end
        join
        check("fill_fifth_after_release", int'(a4 > rel), 1);
        drain("fill");

        // Reset while waiting on the framework
        fw_never = 1'b1;
        push(6'd9, k);
        push(6'd30, k);
        step(4);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        fw_never = 1'b0;
        step(2);
        release_reset("midreset");
        repeat (30) @(negedge clk);
        check("midreset_idle", int'(busy), 0);
        step(1);

        // Randomized traffic
        rsp_rand = 1'b1;
        fw_max_delay = 4;
        for (int i = 0; i < 40; i++) begin
            push(6'($urandom_range(0, 63)), k);
            if ($urandom_range(0, 2) == 0) step($urandom_range(1, 5));
        end
        drain("random");
        rsp_rand = 1'b0;

        check("final_accepted_nonzero", int'(accepted > 40), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/chest_dispatcher.md
CHEST_DISPATCHER -- requirements
Module: chest_dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request queue entries (power of two, at least 2).
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in WAIT (at least 2).
REQ-003 Parameter NUM_ALGOS, default 50: algorithm ids 0..NUM_ALGOS-1 are valid.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid  input  1  upstream request valid.
REQ-007 req_algo  input  6  requested algorithm id.
REQ-008 req_ready  output  1  queue can accept a request.
REQ-009 algo_select  output  6  registered id driven to the framework select input.
REQ-010 algorithm_ready  input  1  registered ready returned by the framework.
REQ-011 rsp_valid  output  1  response valid.
REQ-012 rsp_algo  output  6  id the response refers to.
REQ-013 rsp_status  output  2  00 OK, 01 invalid id, 10 timeout; 11 is never driven.
REQ-014 rsp_ready  input  1  downstream accepts the response.
REQ-015 busy  output  1  high when the FSM is not in IDLE or the queue is non-empty.

Function
REQ-016 Push happens only when req_valid && req_ready; req_ready SHALL equal !full, and a same-cycle pop does not free a slot for that cycle's push.
REQ-017 Queue order is strict FIFO; a request presented while full is held by upstream and never dropped.
REQ-018 The FSM states are IDLE, SELECT, WAIT and RESP.
REQ-019 IDLE with queue non-empty: pop and latch the id; if id >= NUM_ALGOS go to RESP with status 01 and leave algo_select at idle; otherwise set algo_select = id and go to SELECT.
REQ-020 SELECT lasts exactly one cycle (framework register latency), then goes to WAIT, clearing the timeout counter.
REQ-021 WAIT with algorithm_ready=1: go to RESP with status 00.
REQ-022 WAIT timeout: after TIMEOUT_CYCLES consecutive WAIT cycles with algorithm_ready=0, go to RESP with status 10; ready wins if both occur in the same cycle.
REQ-023 On entering RESP and in IDLE, algo_select SHALL be 6'h3F, the idle select value (>= NUM_ALGOS, which forces the framework ready low).
REQ-024 In RESP, rsp_valid=1 and rsp_algo/rsp_status stay stable until rsp_ready=1; on that handshake the FSM returns to IDLE.
REQ-025 Latency: a valid-id request accepted at edge k into an empty queue with the FSM idle and the framework answering promptly gives rsp_valid high from edge k+3.
REQ-026 Only one request is outstanding at the framework at any time.

Reset
REQ-027 While rst_n=0: queue empty, FSM in IDLE, and timeout counter 0.
REQ-028 While rst_n=0: req_ready=0, algo_select=6'h3F, rsp_valid=0, rsp_algo=0, rsp_status=00 and busy=0.
REQ-029 Reset mid-operation discards queued and in-flight requests and produces no response for them.
REQ-030 req_ready rises on the first edge after rst_n deasserts.

Configuration
REQ-031 With macro CHEST_DISPATCH_TIMEOUT_EN defined, REQ-022 applies.
REQ-032 Without CHEST_DISPATCH_TIMEOUT_EN: no timeout counter, WAIT persists until algorithm_ready=1, and status 10 is never produced.

Structure
REQ-033 Shared package chest_pkg holds: the FSM state enum, the rsp_status codes, ALGO_IDLE_SEL = 6'h3F, and the NUM_ALGOS default.
REQ-034 The request queue is a separate sub-module, chest_req_fifo (parameterised depth, 6-bit data, full/empty flags).

Verification
REQ-035 Push id 7 with the framework model answering 1 cycle after select: rsp_valid at k+3, rsp_algo=7, status 00, and algo_select back to 6'h3F after the handshake.
REQ-036 Push id 55: status 01 and algo_select stays 6'h3F throughout.
REQ-037 With TIMEOUT_EN, a framework model that never raises ready: status 10 after exactly 16 WAIT cycles; without TIMEOUT_EN, busy stays high indefinitely.
REQ-038 Push 5 back-to-back with rsp_ready=0: 4 accepted, then req_ready=0; release rsp_ready and responses arrive in order, with the 5th accepted once a slot frees.
REQ-039 Assert rst_n=0 during WAIT: outputs take their reset values immediately, and after release no stale response appears.
